// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into short, double and long presses with a hold level.
// Optional macro BUTTON_AUTOREPEAT_EN: re-pulse long_press every REPEAT_MS while held.
module button_press_classifier #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned LONG_MS   = 5000,
  parameter int unsigned DBL_MS    = 300,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic db_level,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic hold_active,
  output logic busy
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [15:0] LONG_LIM = 16'(LONG_MS);
  localparam logic [15:0] DBL_LIM  = 16'(DBL_MS);
  localparam logic [15:0] MS_SAT   = 16'hFFFF;

  if (TICK_DIV < 2 || LONG_MS < 1 || LONG_MS > 65535 || DBL_MS < 1 || DBL_MS > 65535 ||
      REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_bad_param
    $error("button_press_classifier: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_WAIT2  = 3'd2,
    S_PRESS2 = 3'd3,
    S_HOLD   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            prev_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [15:0]     ms_q, ms_d;
  logic            short_q, short_d;
  logic            double_q, double_d;
  logic            long_q, long_d;
  logic            hold_q, hold_d;
  logic            busy_q, busy_d;

  logic            rise, fall;
  logic            ms_tick;
  logic [15:0]     ms_next;
  logic            long_due, dbl_due;
  logic            restart;

  assign rise = db_level & ~prev_q;
  assign fall = ~db_level & prev_q;

  // Deadlines are judged on the post-tick value so they fire on the tick edge itself.
  assign ms_tick  = (presc_q == PRESC_MAX);
  assign ms_next  = (ms_tick && ms_q != MS_SAT) ? ms_q + 16'd1 : ms_q;
  assign long_due = (ms_next >= LONG_LIM);
  assign dbl_due  = (ms_next >= DBL_LIM);

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [15:0] REP_LIM = 16'(REPEAT_MS);
  logic rep_due;
  assign rep_due = (ms_next >= REP_LIM);
`endif

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    restart  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rise) state_d = S_PRESS1;
      end
      S_PRESS1: begin
        if (fall) begin
          state_d = S_WAIT2;
        end else if (long_due) begin
          state_d = S_HOLD;
          long_d  = 1'b1;
        end
      end
      S_WAIT2: begin
        if (rise) begin
          state_d = S_PRESS2;
        end else if (dbl_due) begin
          state_d = S_IDLE;
          short_d = 1'b1;
        end
      end
      S_PRESS2: begin
        if (fall) begin
          state_d  = S_IDLE;
          double_d = 1'b1;
        end else if (long_due) begin
          state_d = S_HOLD;
          long_d  = 1'b1;
        end
      end
      S_HOLD: begin
        if (fall) begin
          state_d = S_IDLE;
`ifdef BUTTON_AUTOREPEAT_EN
        end else if (rep_due) begin
          long_d  = 1'b1;
          restart = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) restart = 1'b1;

    if (restart) begin
      presc_d = '0;
      ms_d    = '0;
    end else begin
      presc_d = ms_tick ? '0 : presc_q + PW'(1);
      ms_d    = ms_next;
    end

    hold_d = (state_d == S_HOLD);
    busy_d = (state_d != S_IDLE);
  end

  // prev_q resets high so a button held through reset needs a fresh press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      prev_q   <= 1'b1;
      presc_q  <= '0;
      ms_q     <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      hold_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= db_level;
      presc_q  <= presc_d;
      ms_q     <= ms_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
    end
  end

  assign short_press  = short_q;
  assign double_press = double_q;
  assign long_press   = long_q;
  assign hold_active  = hold_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Self-checking bench for button_press_classifier: directed gesture scenarios plus randomized
// level sequences compared against an elapsed-time gesture model.
module tb_button_press_classifier;

  localparam int TD = 4;
  localparam int LM = 10;
  localparam int DM = 5;
  localparam int RM = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic db_level = 1'b0;
  logic short_press, double_press, long_press, hold_active, busy;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  button_press_classifier #(
    .TICK_DIV (TD),
    .LONG_MS  (LM),
    .DBL_MS   (DM),
    .REPEAT_MS(RM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .db_level    (db_level),
    .short_press (short_press),
    .double_press(double_press),
    .long_press  (long_press),
    .hold_active (hold_active),
    .busy        (busy)
  );

  // Reference: gesture phase plus cycles elapsed since the phase began; a deadline of
  // N ms expires exactly N*TD clock edges after the phase was entered.
  int m_phase = 0;  // 0 idle, 1 first press, 2 gap, 3 second press, 4 held long
  int m_t = 0;
  bit m_prev = 1'b1;
  bit e_short, e_double, e_long, e_hold, e_busy;

  always @(posedge clk) begin
    bit r, f;
    if (!reset) begin
      m_phase = 0; m_t = 0; m_prev = 1'b1;
      e_short = 0; e_double = 0; e_long = 0; e_hold = 0; e_busy = 0;
    end else begin
      r = db_level && !m_prev;
      f = !db_level && m_prev;
      m_prev = db_level;
      m_t = m_t + 1;
      e_short = 0; e_double = 0; e_long = 0;
      case (m_phase)
        0: if (r) begin m_phase = 1; m_t = 0; end
        1: if (f) begin m_phase = 2; m_t = 0; end
           else if (m_t == LM * TD) begin e_long = 1; m_phase = 4; m_t = 0; end
        2: if (r) begin m_phase = 3; m_t = 0; end
           else if (m_t == DM * TD) begin e_short = 1; m_phase = 0; m_t = 0; end
        3: if (f) begin e_double = 1; m_phase = 0; m_t = 0; end
           else if (m_t == LM * TD) begin e_long = 1; m_phase = 4; m_t = 0; end
        4: if (f) begin m_phase = 0; m_t = 0; end
`ifdef BUTTON_AUTOREPEAT_EN
           else if (m_t == RM * TD) begin e_long = 1; m_t = 0; end
`endif
        default: m_phase = 0;
      endcase
      e_hold = (m_phase == 4);
      e_busy = (m_phase != 0);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    db_level = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    logic [4:0] o;
    reset = 1'b0;
    db_level = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      o = {short_press, double_press, long_press, hold_active, busy};
      checks++;
      if (o !== 5'b0) $display("FAIL reset_outputs cyc%0d: got %b want 00000", i, o);
      else passed++;
    end
    reset = 1'b1;
    repeat (6) step();
    o = {short_press, double_press, long_press, hold_active, busy};
    checks++;
    if (o !== 5'b0) $display("FAIL held_through_reset_ignored: got %b want 00000", o);
    else passed++;
    db_level = 1'b0;
    step();
    db_level = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1) $display("FAIL busy_after_fresh_press: got %b want 1", busy);
    else passed++;
    drain(40);
  endtask

  task automatic test_short();
    int n = 0, pos = -1, others = 0;
    logic busy_at = 1'bx, busy_before = 1'bx, prev_busy;
    db_level = 1'b1;
    repeat (8) step();
    db_level = 1'b0;
    prev_busy = busy;
    for (int k = 0; k < 40; k++) begin
      step();
      if (short_press) begin n++; pos = k; busy_at = busy; busy_before = prev_busy; end
      if (double_press || long_press) others++;
      prev_busy = busy;
    end
    checks++;
    if (n != 1) $display("FAIL short_count: got %0d want 1", n); else passed++;
    checks++;
    if (pos != DM * TD) $display("FAIL short_latency: got %0d want %0d", pos, DM * TD); else passed++;
    checks++;
    if (busy_at !== 1'b0 || busy_before !== 1'b1)
      $display("FAIL short_busy_drop: got %b%b want 10", busy_before, busy_at);
    else passed++;
    checks++;
    if (others != 0) $display("FAIL short_other_pulses: got %0d want 0", others); else passed++;
  endtask

  task automatic test_double();
    int n = 0, pos = -1, shorts = 0, longs = 0;
    db_level = 1'b1; repeat (8) step();
    db_level = 1'b0; repeat (8) step();
    db_level = 1'b1; repeat (8) step();
    db_level = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (double_press) begin n++; pos = k; end
      if (short_press) shorts++;
      if (long_press) longs++;
    end
    checks++;
    if (n != 1) $display("FAIL double_count: got %0d want 1", n); else passed++;
    checks++;
    if (pos != 0) $display("FAIL double_latency: got %0d want 0", pos); else passed++;
    checks++;
    if (shorts != 0 || longs != 0) $display("FAIL double_no_short: got %0d/%0d want 0/0", shorts, longs);
    else passed++;
  endtask

  task automatic test_long();
    int n = 0, first = -1, second = -1, hold_err = 0, shorts = 0, exp_n;
`ifdef BUTTON_AUTOREPEAT_EN
    exp_n = 2;
`else
    exp_n = 1;
`endif
    db_level = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (long_press) begin
        n++;
        if (first < 0) first = k; else if (second < 0) second = k;
      end
      if (hold_active !== (k >= LM * TD)) hold_err++;
      if (short_press || double_press) shorts++;
    end
    db_level = 1'b0;
    step();
    checks++;
    if (n != exp_n) $display("FAIL long_count: got %0d want %0d", n, exp_n); else passed++;
    checks++;
    if (first != LM * TD) $display("FAIL long_latency: got %0d want %0d", first, LM * TD); else passed++;
    checks++;
    if (hold_err != 0) $display("FAIL hold_window: got %0d bad cycles want 0", hold_err); else passed++;
    checks++;
    if (hold_active !== 1'b0 || busy !== 1'b0)
      $display("FAIL hold_release: got %b%b want 00", hold_active, busy);
    else passed++;
`ifdef BUTTON_AUTOREPEAT_EN
    checks++;
    if (second - first != RM * TD) $display("FAIL repeat_period: got %0d want %0d", second - first, RM * TD);
    else passed++;
`endif
    repeat (30) begin
      step();
      if (short_press || double_press || long_press) shorts++;
    end
    checks++;
    if (shorts != 0) $display("FAIL long_no_other: got %0d want 0", shorts); else passed++;
  endtask

  task automatic test_edge_deadline();
    int shorts = 0, longs = 0;
    db_level = 1'b1;
    for (int k = 0; k < LM * TD; k++) begin
      step();
      if (long_press) longs++;
    end
    db_level = 1'b0;
    repeat (40) begin
      step();
      if (long_press) longs++;
      if (short_press) shorts++;
    end
    checks++;
    if (longs != 0) $display("FAIL deadline_no_long: got %0d want 0", longs); else passed++;
    checks++;
    if (shorts != 1) $display("FAIL deadline_short: got %0d want 1", shorts); else passed++;
  endtask

  task automatic test_reset_in_hold();
    int pulses = 0, busy_seen = 0;
    db_level = 1'b1;
    repeat (LM * TD + 3) step();
    checks++;
    if (hold_active !== 1'b1) $display("FAIL hold_reached: got %b want 1", hold_active); else passed++;
    reset = 1'b0;
    step();
    checks++;
    if (hold_active !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_in_hold: got %b%b want 00", hold_active, busy);
    else passed++;
    reset = 1'b1;
    repeat (10) begin
      step();
      if (short_press || double_press || long_press) pulses++;
      if (busy) busy_seen++;
    end
    db_level = 1'b0;
    repeat (30) begin
      step();
      if (short_press || double_press || long_press) pulses++;
      if (busy) busy_seen++;
    end
    checks++;
    if (pulses != 0 || busy_seen != 0)
      $display("FAIL reset_abort_quiet: got %0d pulses %0d busy want 0 0", pulses, busy_seen);
    else passed++;
  endtask

  task automatic test_random();
    int seg, bad = 0, multi = 0;
    logic [4:0] o, e;
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
      end
      db_level = ~db_level;
      case ($urandom_range(0, 3))
        0: seg = $urandom_range(1, 12);
        1: seg = $urandom_range(DM * TD - 2, DM * TD + 2);
        2: seg = $urandom_range(LM * TD - 2, LM * TD + 2);
        default: seg = $urandom_range(1, 70);
      endcase
      repeat (seg) begin
        step();
        o = {short_press, double_press, long_press, hold_active, busy};
        e = {e_short, e_double, e_long, e_hold, e_busy};
        checks++;
        if (o !== e) begin
          bad++;
          if (bad <= 10) $display("FAIL random_vs_model t=%0t: got %b want %b", $time, o, e);
        end else passed++;
        if ($countones(o[4:2]) > 1) multi++;
      end
    end
    checks++;
    if (multi != 0) $display("FAIL one_pulse_per_cycle: got %0d want 0", multi); else passed++;
    drain(40);
  endtask

  initial begin
    test_reset();
    test_short();
    drain(10);
    test_double();
    drain(10);
    test_long();
    test_edge_deadline();
    test_reset_in_hold();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/button_press_classifier.md
Name: button_press_classifier

Overview:
- Sits directly downstream of the button debouncer and consumes its debounced level output.
- Classifies each gesture on one button as a short press, double press or long press (5 s default), and reports a hold level.
- Emits single-cycle event pulses to the application FSM (pet menu/actions).
- One instance per button; time is measured in ms by an internal prescaler.

Parameters:
TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz board clock); minimum 2
LONG_MS, 5000, press duration in ms that qualifies as long press; range 1..65535
DBL_MS, 300, max gap in ms between release and second press for a double press; range 1..65535
REPEAT_MS, 200, auto-repeat period in ms while held (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset; sampled on rising edge of clk
db_level  in  1  debounced button level from the debouncer; 1 = pressed
short_press  out  1  one-cycle pulse: single short press confirmed
double_press  out  1  one-cycle pulse: two short presses within DBL_MS
long_press  out  1  one-cycle pulse: press held LONG_MS
hold_active  out  1  level: 1 while held after long_press, until release
busy  out  1  level: 1 whenever the FSM is not in IDLE

Behaviour:
- Reset (reset==0 at posedge clk):
  - State goes to IDLE; prescaler and ms counter go to 0.
  - All outputs go to 0.
  - prev_level is set to 1, so a button already held through reset is ignored until it is released and pressed again.
- Edge detection:
  - prev_level <= db_level every cycle.
  - rise = db_level & ~prev_level; fall = ~db_level & prev_level.
- Timebase:
  - The prescaler counts 0..TICK_DIV-1 and produces ms_tick when it wraps.
  - A 16-bit ms counter increments on ms_tick and saturates at 65535.
  - Both counters clear on every state transition, so timing starts at the entry cycle.
- States:
  - IDLE: rise -> PRESS1.
  - PRESS1:
    - fall with ms < LONG_MS -> WAIT2.
    - ms reaches LONG_MS while held -> long_press pulse, go to HOLD.
  - HOLD: hold_active=1; fall -> IDLE, with no other event.
  - WAIT2:
    - rise with ms < DBL_MS -> PRESS2.
    - ms reaches DBL_MS -> short_press pulse, go to IDLE.
  - PRESS2:
    - fall with ms < LONG_MS -> double_press pulse, go to IDLE.
    - ms reaches LONG_MS -> long_press pulse, go to HOLD; the first press is discarded and no short_press is emitted.
- Simultaneous events:
  - If a deadline and an edge occur in the same cycle, the edge wins (e.g. a fall in PRESS1 on the LONG_MS cycle gives WAIT2).
  - rise and fall cannot coincide.
- Outputs:
  - All outputs are registered.
  - Pulses assert in the cycle after the triggering condition and last exactly 1 cycle.
  - hold_active and busy change in the same cycle as the state register.
- At most one of short_press, double_press or long_press pulses per cycle.
- Reset asserted mid-gesture (any state): the in-flight gesture is aborted and no pulse is emitted.

Optional Feature:
- Macro: BUTTON_AUTOREPEAT_EN.
- Defined:
  - In HOLD, long_press re-pulses every REPEAT_MS ms for as long as the button stays pressed.
  - The first repeat comes REPEAT_MS after the initial long_press.
  - The ms counter clears on each repeat.
- Undefined:
  - long_press pulses once per hold.
  - REPEAT_MS is ignored and the repeat logic is not synthesized.

Test Plan (TICK_DIV=4, LONG_MS=10, DBL_MS=5, REPEAT_MS=3):
- reset low for 3 cycles with db_level=1, then release reset -> all outputs 0 and no event; db_level falls then rises -> busy=1.
- db_level high 8 cycles (2 ms), then low -> exactly one short_press, 20-22 cycles after the fall; busy returns to 0 the same cycle; no other pulses.
- high 8 cycles, low 8 cycles, high 8 cycles, low -> one double_press 1 cycle after the second fall; no short_press.
- high held 60 cycles -> long_press once, 40-41 cycles after the rise; hold_active=1 until the fall, then 0; no short_press.
  - With BUTTON_AUTOREPEAT_EN: further long_press every 12 cycles while held.
- db_level toggled in PRESS1 so the fall lands on the LONG_MS deadline cycle -> no long_press; the gesture resolves as short_press.
- reset pulled low in HOLD -> hold_active and busy drop to 0 after that edge; no pulse emitted through the release.
